// File: rtl/otp_letter_encoder.sv
// otp_letter_encoder: debounced letter-commit producer for display_decoder.
// Samples a 5-bit letter code on a clean button press, draws a one-time-pad
// key from an 8-bit LFSR and presents encrypted/decrypted codes (mod 27)
// together with a single-cycle enable strobe.
module otp_letter_encoder #(
  parameter logic [19:0] DEBOUNCE_CYCLES = 20'd500000,
  parameter logic [7:0]  SEED            = 8'hA5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       button,
  input  logic [4:0] switch_val_in,
  output logic [4:0] encrypted_text,
  output logic [4:0] decrypted_text,
  output logic       enable,
  output logic [2:0] letter_index,
  output logic       busy,
  output logic       input_error
);

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_ENC      = 3'd1;
  localparam logic [2:0] ST_DEC      = 3'd2;
  localparam logic [2:0] ST_STROBE   = 3'd3;
  localparam logic [2:0] ST_CLEAR    = 3'd4;
  localparam logic [2:0] ST_WAIT_REL = 3'd5;

  logic        sync1_q, sync1_d;
  logic        sync2_q, sync2_d;
  logic        stable_q, stable_d;
  logic        stable_prev_q, stable_prev_d;
  logic [19:0] cnt_q, cnt_d;
  logic [2:0]  state_q, state_d;
  logic [7:0]  lfsr_q, lfsr_d;
  logic [4:0]  plain_q, plain_d;
  logic [4:0]  key_q, key_d;
  logic [4:0]  enc_q, enc_d;
  logic [4:0]  enc_out_q, enc_out_d;
  logic [4:0]  dec_out_q, dec_out_d;
  logic [2:0]  letter_index_q, letter_index_d;
  logic        input_error_q, input_error_d;

  logic        press;
  logic [4:0]  lfsr_low;
  logic [4:0]  key_now;
  logic [5:0]  sum;
  logic [5:0]  enc_full;
  logic [5:0]  dec_full;
  logic [7:0]  lfsr_next;

  // Synchronise the raw button and accept a new level only after it has differed from the stable level long enough
  always_comb begin
    sync1_d       = button;
    sync2_d       = sync1_q;
    stable_d      = stable_q;
    cnt_d         = cnt_q;
    stable_prev_d = stable_q;
    if (sync2_q == stable_q) begin
      cnt_d = 20'd0;
    end else if (cnt_q == DEBOUNCE_CYCLES - 20'd1) begin
      stable_d = sync2_q;
      cnt_d    = 20'd0;
    end else begin
      cnt_d = cnt_q + 20'd1;
    end
  end

  assign press = stable_q & ~stable_prev_q;

  // Key reduction, mod-27 arithmetic and the next LFSR value, kept 6 bits wide so nothing truncates before compares
  always_comb begin
    lfsr_low  = lfsr_q[4:0];
    key_now   = (lfsr_low < 5'd27) ? lfsr_low : (lfsr_low - 5'd27);
    sum       = {1'b0, plain_q} + {1'b0, key_q};
    enc_full  = (sum >= 6'd27) ? (sum - 6'd27) : sum;
    dec_full  = ({1'b0, enc_q} >= {1'b0, key_q}) ? ({1'b0, enc_q} - {1'b0, key_q})
                                                 : ({1'b0, enc_q} + 6'd27 - {1'b0, key_q});
    lfsr_next = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
  end

  // Commit sequencer: sample on press, encrypt, decrypt, strobe, then wait for the button to be released
  always_comb begin
    state_d        = state_q;
    lfsr_d         = lfsr_q;
    plain_d        = plain_q;
    key_d          = key_q;
    enc_d          = enc_q;
    enc_out_d      = enc_out_q;
    dec_out_d      = dec_out_q;
    letter_index_d = letter_index_q;
    input_error_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (press) begin
          if (letter_index_q == 3'd4) begin
            state_d = ST_CLEAR;
          end else if (switch_val_in > 5'd26) begin
            input_error_d = 1'b1;
            state_d       = ST_WAIT_REL;
          end else begin
            plain_d = switch_val_in;
            key_d   = key_now;
            state_d = ST_ENC;
          end
        end
      end
      ST_ENC: begin
        enc_d   = enc_full[4:0];
        state_d = ST_DEC;
      end
      ST_DEC: begin
        enc_out_d = enc_q;
        dec_out_d = dec_full[4:0];
        state_d   = ST_STROBE;
      end
      ST_STROBE: begin
        letter_index_d = letter_index_q + 3'd1;
        if (letter_index_q < 3'd4) begin
          lfsr_d = lfsr_next;
        end
        state_d = ST_WAIT_REL;
      end
      ST_CLEAR: begin
        letter_index_d = 3'd0;
        state_d        = ST_WAIT_REL;
      end
      ST_WAIT_REL: begin
        if (!stable_q) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers with synchronous reset that aborts any commit in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q        <= 1'b0;
      sync2_q        <= 1'b0;
      stable_q       <= 1'b0;
      stable_prev_q  <= 1'b0;
      cnt_q          <= 20'd0;
      state_q        <= ST_IDLE;
      lfsr_q         <= SEED;
      plain_q        <= 5'd0;
      key_q          <= 5'd0;
      enc_q          <= 5'd0;
      enc_out_q      <= 5'd0;
      dec_out_q      <= 5'd0;
      letter_index_q <= 3'd0;
      input_error_q  <= 1'b0;
    end else begin
      sync1_q        <= sync1_d;
      sync2_q        <= sync2_d;
      stable_q       <= stable_d;
      stable_prev_q  <= stable_prev_d;
      cnt_q          <= cnt_d;
      state_q        <= state_d;
      lfsr_q         <= lfsr_d;
      plain_q        <= plain_d;
      key_q          <= key_d;
      enc_q          <= enc_d;
      enc_out_q      <= enc_out_d;
      dec_out_q      <= dec_out_d;
      letter_index_q <= letter_index_d;
      input_error_q  <= input_error_d;
    end
  end

  assign encrypted_text = enc_out_q;
  assign decrypted_text = dec_out_q;
  assign enable         = (state_q == ST_STROBE) || (state_q == ST_CLEAR);
  assign busy           = (state_q != ST_IDLE);
  assign letter_index   = letter_index_q;
  assign input_error    = input_error_q;

endmodule
